regfile_wr_arb: RTL and testbench
=================================

# regfile_wr_arb

Write-port arbiter and scheduler for the 32×32 register file. It shares the register file's single write port between the in-order pipeline writeback (port A) and a long-latency unit such as mult/div or an uncached load (port B). Port B results are buffered in a small FIFO. A starvation guard periodically forces a port B grant. The block also reports pending-write hazards to decode and drops all writes to $zero, because the register file does not protect register 0 outside reset.

## Interface
- DEPTH, 2, port B FIFO entries; power of two, ≥2
- MAX_WAIT, 4, cycles a non-empty FIFO head may be refused before a forced B grant; ≥1
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- a_valid  in  1  pipeline writeback request
- a_ready  out  1  A accepted when a_valid && a_ready
- a_addr  in  5  A destination register
- a_data  in  32  A write data
- b_valid  in  1  long-latency result request
- b_ready  out  1  FIFO not full; push when b_valid && b_ready
- b_addr  in  5  B destination register
- b_data  in  32  B write data
- rd_addr1, rd_addr2  in  5 each  decode-stage read addresses (rs, rt)
- rd_pending1, rd_pending2  out  1 each  write to that address not yet committed
- wr_en  out  1  register file write enable
- wr_addr  out  5  register file write address
- wr_data  out  32  register file write data

## Operation
- Port B is always pushed into the FIFO; there is no bypass. Only the FIFO head competes for the write port.
- Each cycle at most one grant is issued, in priority order:
  1. Forced B: FIFO non-empty and wait_cnt == MAX_WAIT. FIFO pops, a_ready=0 this cycle, wait_cnt clears.
  2. A: a_valid with no forced B. A is accepted.
  3. B: FIFO non-empty and a_valid=0. FIFO pops, wait_cnt clears.
- wait_cnt (width clog2(MAX_WAIT+1)):
  - increments when the FIFO is non-empty and the head is not granted;
  - saturates at MAX_WAIT;
  - clears on any B grant or when the FIFO is empty.
- a_ready = !reset && !forced_B. It is combinational from registered state only, never from a_valid.
- b_ready = !reset && (count < DEPTH). It is computed from the current count only, so a pop does not free a slot for a push in the same cycle.
- A push and a pop in the same cycle leave count unchanged; FIFO order is preserved.
- $zero filter: a grant with address 0 completes the handshake and pops or accepts normally, but the output stage loads wr_en=0.
- Hazard flags: rd_pendingN=1 when rd_addrN≠0 and rd_addrN matches either of:
  - any valid FIFO entry address;
  - the address granted this cycle.
- WAW ordering between A and B is the producers' responsibility; issue logic uses the pending flags to avoid it. The arbiter never reorders B entries.

## Timing
- The output stage is registered. A grant in cycle N gives wr_en/wr_addr/wr_data in cycle N+1. The register file commits at the negedge inside N+1, so a registered read at the end of N+1 returns the new value.
- Port A latency: accept in N, write in N+1.
- Port B minimum latency: push in N, grant in N+1, write in N+2.
- wr_en is high for exactly one cycle per granted non-zero write. wr_addr and wr_data hold their last values when wr_en=0.
- Reset values:
  - wr_en=0, wr_addr=0, wr_data=0;
  - FIFO empty, wait_cnt=0;
  - a_ready=0 and b_ready=0 while reset is high; both are 1 in the first cycle after reset.
- Reset mid-operation discards all FIFO entries and any in-flight grant with no write issued. wr_en is 0 in the cycle after reset is asserted.
- Full FIFO with b_valid high: b_ready=0 and the data is held by the producer. b_ready rises the cycle after a pop.

## Structure
- Shared package regfile_pkg: REG_ADDR_W=5, REG_DATA_W=32, ZERO_REG=5'd0, and a packed wb_req_t {addr, data} struct used by both ports and the FIFO.
- Sub-module wb_fifo: synchronous FIFO of wb_req_t with DEPTH parameter, push/pop/full/empty/count outputs, and per-entry valid and addr outputs for the hazard compare.
- Top level contains the grant logic, wait_cnt, $zero filter, hazard compare and output register.

## Test plan
- Reset, then a_valid with addr=5, data=0xDEADBEEF → next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF; a_ready=1 throughout.
- b_valid addr=7, data=0x1234 with a_valid=0 → push in N, wr_en with addr 7 and data 0x1234 in N+2; rd_pending1=1 for rd_addr1=7 during N+1.
- a_valid held high continuously while FIFO holds B addr=9 → A wins MAX_WAIT=4 cycles, then a_ready=0 for one cycle and reg 9 is written; A resumes the next cycle.
- DEPTH=2 FIFO filled with A busy → b_ready=0. A third b_valid is held and pushed only the cycle after the first pop; entries are written in push order.
- a_valid with addr=0, data=0xFFFFFFFF → a_ready=1 handshake completes and wr_en stays 0; rd_pending for rd_addr=0 is always 0.
- Reset asserted with 2 FIFO entries pending → wr_en=0 the next cycle, FIFO empty, no write to either address after reset releases.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types for the register file write path.
// Write requests from both producers and FIFO entries use wb_req_t.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding long-latency write requests.
// Exposes per-slot valid/addr so the owner can flag pending writes.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_push,
    input  logic [REG_ADDR_W-1:0]         i_push_addr,
    input  logic [REG_DATA_W-1:0]         i_push_data,
    input  logic                          i_pop,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [CW-1:0]                 o_count,
    output logic [REG_ADDR_W-1:0]         o_head_addr,
    output logic [REG_DATA_W-1:0]         o_head_data,
    output logic [DEPTH-1:0]              o_ent_vld,
    output logic [DEPTH*REG_ADDR_W-1:0]   o_ent_addr
);

    wb_req_t          r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [DEPTH-1:0] r_vld;

    logic             w_push;
    logic             w_pop;
    logic [DEPTH-1:0] w_vld_nxt;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    assign o_head_addr = r_mem[r_rd_ptr].addr;
    assign o_head_data = r_mem[r_rd_ptr].data;
    assign o_ent_vld   = r_vld;

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        assign o_ent_addr[g*REG_ADDR_W +: REG_ADDR_W] = r_mem[g].addr;
    end

    // Slot occupancy after this cycle's pop and push.
    always_comb begin
        w_vld_nxt = r_vld;
        if (w_pop) begin
            w_vld_nxt[r_rd_ptr] = 1'b0;
        end
        if (w_push) begin
            w_vld_nxt[r_wr_ptr] = 1'b1;
        end
    end

    // Storage array; contents are don't-care until marked valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{addr: i_push_addr, data: i_push_data};
        end
    end

    // Pointers, occupancy and per-slot valid bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_vld    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_vld <= w_vld_nxt;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wr_arb.sv
// Shares the register file write port between pipeline writeback (A)
// and a buffered long-latency producer (B) with a starvation guard.
module regfile_wr_arb
    import regfile_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [REG_ADDR_W-1:0] a_addr,
    input  logic [REG_DATA_W-1:0] a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [REG_ADDR_W-1:0] b_addr,
    input  logic [REG_DATA_W-1:0] b_data,
    input  logic [REG_ADDR_W-1:0] rd_addr1,
    input  logic [REG_ADDR_W-1:0] rd_addr2,
    output logic                  rd_pending1,
    output logic                  rd_pending2,
    output logic                  wr_en,
    output logic [REG_ADDR_W-1:0] wr_addr,
    output logic [REG_DATA_W-1:0] wr_data
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                        w_full;
    logic                        w_empty;
    logic [CW-1:0]               w_count;
    logic [REG_ADDR_W-1:0]       w_head_addr;
    logic [REG_DATA_W-1:0]       w_head_data;
    logic [DEPTH-1:0]            w_ent_vld;
    logic [DEPTH*REG_ADDR_W-1:0] w_ent_addr;

    logic                        w_forced;
    logic                        w_grant_a;
    logic                        w_grant_b;
    logic                        w_gnt_any;
    logic                        w_push;
    logic [REG_ADDR_W-1:0]       w_gnt_addr;
    logic [REG_DATA_W-1:0]       w_gnt_data;

    logic [WW-1:0]               r_wait;

    // Forced B depends only on registered state, so a_ready never
    // looks at a_valid.
    assign w_forced  = (w_count != '0) && (r_wait == WW'(MAX_WAIT));
    assign a_ready   = !reset && !w_forced;
    assign b_ready   = !reset && !w_full;

    assign w_grant_a = a_valid && a_ready;
    assign w_grant_b = !reset && !w_empty && !w_grant_a;
    assign w_gnt_any = w_grant_a || w_grant_b;
    assign w_push    = b_valid && b_ready;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_addr (b_addr),
        .i_push_data (b_data),
        .i_pop       (w_grant_b),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_ent_vld   (w_ent_vld),
        .o_ent_addr  (w_ent_addr)
    );

    // Select the request that owns the write port this cycle.
    always_comb begin
        w_gnt_addr = a_addr;
        w_gnt_data = a_data;
        if (w_grant_b) begin
            w_gnt_addr = w_head_addr;
            w_gnt_data = w_head_data;
        end
    end

    // Flag reads whose register still has a write outstanding.
    always_comb begin
        rd_pending1 = 1'b0;
        rd_pending2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_ent_vld[i] &&
                w_ent_addr[i*REG_ADDR_W +: REG_ADDR_W] == rd_addr1) begin
                rd_pending1 = 1'b1;
            end
            if (w_ent_vld[i] &&
                w_ent_addr[i*REG_ADDR_W +: REG_ADDR_W] == rd_addr2) begin
                rd_pending2 = 1'b1;
            end
        end
        if (w_gnt_any && w_gnt_addr == rd_addr1) begin
            rd_pending1 = 1'b1;
        end
        if (w_gnt_any && w_gnt_addr == rd_addr2) begin
            rd_pending2 = 1'b1;
        end
        if (rd_addr1 == ZERO_REG) begin
            rd_pending1 = 1'b0;
        end
        if (rd_addr2 == ZERO_REG) begin
            rd_pending2 = 1'b0;
        end
    end

    // Count cycles the FIFO head has been refused, saturating.
    always_ff @(posedge clk) begin
        if (reset || w_empty || w_grant_b) begin
            r_wait <= '0;
        end else if (r_wait != WW'(MAX_WAIT)) begin
            r_wait <= r_wait + WW'(1);
        end
    end

    // Registered write port; $zero grants retire without a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= w_gnt_any && (w_gnt_addr != ZERO_REG);
            if (w_gnt_any && (w_gnt_addr != ZERO_REG)) begin
                wr_addr <= w_gnt_addr;
                wr_data <= w_gnt_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Directed and randomized checks of regfile_wr_arb against a
// queue-based reference model of the arbitration rules.
module tb_regfile_wr_arb;
    import regfile_pkg::*;

    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [4:0]  a_addr = '0;
    logic [31:0] a_data = '0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [4:0]  b_addr = '0;
    logic [31:0] b_data = '0;
    logic [4:0]  rd_addr1 = '0;
    logic [4:0]  rd_addr2 = '0;
    logic        rd_pending1;
    logic        rd_pending2;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    regfile_wr_arb #(
        .DEPTH    (DEPTH),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_addr      (a_addr),
        .a_data      (a_data),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_addr      (b_addr),
        .b_data      (b_data),
        .rd_addr1    (rd_addr1),
        .rd_addr2    (rd_addr2),
        .rd_pending1 (rd_pending1),
        .rd_pending2 (rd_pending2),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;

    wb_req_t     mq[$];
    int          mwait = 0;
    logic        m_en = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;

    logic        s_ar, s_br, s_p1, s_p2;
    bit          s_bpush;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit pend(input logic [4:0] a, input bit gv,
                                input logic [4:0] g);
        if (a == 5'd0) return 1'b0;
        if (gv && a == g) return 1'b1;
        foreach (mq[i]) if (mq[i].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step(input bit rst, input bit av,
                        input logic [4:0] aa, input logic [31:0] ad,
                        input bit bv, input logic [4:0] ba,
                        input logic [31:0] bd,
                        input logic [4:0] r1, input logic [4:0] r2);
        bit          emp, frc, ga, gb, gv, brdy;
        logic [4:0]  gaddr;
        logic [31:0] gdata;
        reset = rst; a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        rd_addr1 = r1; rd_addr2 = r2;
        #3;
        emp  = (mq.size() == 0);
        frc  = !emp && (mwait >= MAX_WAIT);
        ga   = !rst && av && !frc;
        gb   = !rst && !emp && !ga;
        gv   = ga || gb;
        brdy = !rst && (mq.size() < DEPTH);
        gaddr = ga ? aa : (gb ? mq[0].addr : 5'd0);
        gdata = ga ? ad : (gb ? mq[0].data : 32'd0);
        s_ar = a_ready; s_br = b_ready;
        s_p1 = rd_pending1; s_p2 = rd_pending2;
        chk("a_ready", 32'(a_ready), 32'(!rst && !frc));
        chk("b_ready", 32'(b_ready), 32'(brdy));
        chk("rd_pending1", 32'(rd_pending1), 32'(pend(r1, gv, gaddr)));
        chk("rd_pending2", 32'(rd_pending2), 32'(pend(r2, gv, gaddr)));
        s_bpush = 1'b0;
        if (rst) begin
            mq.delete();
            mwait = 0;
            m_en = 1'b0; m_addr = '0; m_data = '0;
        end else begin
            if (gb || emp) mwait = 0;
            else if (mwait < MAX_WAIT) mwait++;
            m_en = gv && (gaddr != 5'd0);
            if (m_en) begin
                m_addr = gaddr;
                m_data = gdata;
            end
            if (gb) void'(mq.pop_front());
            if (bv && brdy) begin
                s_bpush = 1'b1;
                mq.push_back('{addr: ba, data: bd});
            end
        end
        @(posedge clk);
        #1;
        chk("wr_en", 32'(wr_en), 32'(m_en));
        chk("wr_addr", 32'(wr_addr), 32'(m_addr));
        chk("wr_data", wr_data, m_data);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int lo_idx, lo_cnt, pop_idx, push3_idx, hits;
        logic [4:0] order[$];

        repeat (2) @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_ar", 32'(s_ar), 32'd0);
        chk("rst_br", 32'(s_br), 32'd0);

        step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        chk("a_first_ready", 32'(s_ar), 32'd1);
        chk("a_first_br", 32'(s_br), 32'd1);
        chk("a_wr_en", 32'(wr_en), 32'd1);
        chk("a_wr_addr", 32'(wr_addr), 32'd5);
        chk("a_wr_data", wr_data, 32'hDEADBEEF);

        step(0, 0, 0, 0, 1, 7, 32'h1234, 7, 0);
        chk("b_push_en", 32'(wr_en), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 7, 0);
        chk("b_pend7", 32'(s_p1), 32'd1);
        chk("b_wr_en", 32'(wr_en), 32'd1);
        chk("b_wr_addr", 32'(wr_addr), 32'd7);
        chk("b_wr_data", wr_data, 32'h1234);
        idle(2);

        step(0, 0, 0, 0, 1, 9, 32'h9999, 0, 0);
        lo_idx = -1; lo_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            step(0, 1, 5'(16 + k), $urandom, 0, 0, 0, 9, 0);
            if (!s_ar) begin
                lo_cnt++;
                if (lo_idx < 0) lo_idx = k;
            end
            if (k == 4) chk("force_addr", 32'(wr_addr), 32'd9);
        end
        chk("force_cnt", 32'(lo_cnt), 32'd1);
        chk("force_idx", 32'(lo_idx), 32'd4);
        idle(2);

        step(0, 1, 20, $urandom, 1, 11, 32'h11, 0, 0);
        step(0, 1, 21, $urandom, 1, 12, 32'h12, 0, 0);
        pop_idx = -1; push3_idx = -1;
        for (int k = 0; k < 20 && push3_idx < 0; k++) begin
            step(0, 1, 5'(22 + k % 8), $urandom, 1, 13, 32'h13, 0, 0);
            if (!s_ar && pop_idx < 0) pop_idx = k;
            if (s_bpush) push3_idx = k;
            if (wr_en && wr_addr inside {5'd11, 5'd12, 5'd13})
                order.push_back(wr_addr);
        end
        chk("fill_pop_seen", 32'(pop_idx >= 0), 32'd1);
        chk("fill_push_after_pop", 32'(push3_idx), 32'(pop_idx + 1));
        for (int k = 0; k < 6; k++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, 0);
            if (wr_en && wr_addr inside {5'd11, 5'd12, 5'd13})
                order.push_back(wr_addr);
        end
        chk("order_len", 32'(order.size()), 32'd3);
        if (order.size() == 3) begin
            chk("order0", 32'(order[0]), 32'd11);
            chk("order1", 32'(order[1]), 32'd12);
            chk("order2", 32'(order[2]), 32'd13);
        end

        step(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
        chk("zero_ar", 32'(s_ar), 32'd1);
        chk("zero_p1", 32'(s_p1), 32'd0);
        chk("zero_en", 32'(wr_en), 32'd0);

        step(0, 1, 1, $urandom, 1, 14, 32'h14, 0, 0);
        step(0, 1, 2, $urandom, 1, 15, 32'h15, 0, 0);
        step(1, 1, 3, $urandom, 0, 0, 0, 14, 15);
        chk("rst_mid_en", 32'(wr_en), 32'd0);
        hits = 0;
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 0, 0, 0, 0, 0, 14, 15);
            if (wr_en && (wr_addr == 5'd14 || wr_addr == 5'd15)) hits++;
        end
        chk("rst_no_write", 32'(hits), 32'd0);

        for (int k = 0; k < 1500; k++) begin
            step($urandom_range(63) == 0, 1'($urandom_range(1)),
                 5'($urandom_range(7)), $urandom,
                 1'($urandom_range(1)), 5'($urandom_range(7)), $urandom,
                 5'($urandom_range(7)), 5'($urandom_range(7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
